dyt_sram_ctrl: RTL and testbench

DYT_SRAM_CTRL -- requirements
Module: dyt_sram_ctrl

---
 rtl/common_types.sv | 32 +++
 rtl/dyt_sram_if.sv | 27 ++
 rtl/dyt_mem_align.sv | 57 +++++
 rtl/dyt_sram_ctrl.sv | 136 +++++++++++++
 tb/tb_dyt_sram_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/common_types.sv
// Shared types and constants for the SRAM controller slice.
// Size encoding, FSM states and the access legality check.
package common_types;

  localparam int SRAM_RD_LAT = 2;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_t;

  // Size 3 is illegal; HALF/WORD must be naturally aligned.
  function automatic logic bad_access(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == 2'd3) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dyt_sram_if.sv
// Word-wide SRAM port bundle.
// The controller drives address/data/strobes, the memory returns read data.
interface dyt_sram_if;
  import common_types::*;

  logic [SRAM_ADDR_W-1:0]   sram_address;
  logic [SRAM_DATA_W-1:0]   sram_w_data;
  logic [SRAM_DATA_W/8-1:0] sram_wen;
  logic                     sram_ren;
  logic [SRAM_DATA_W-1:0]   sram_r_data;

  modport ctrl (
    output sram_address,
    output sram_w_data,
    output sram_wen,
    output sram_ren,
    input  sram_r_data
  );

  modport mem (
    input  sram_address,
    input  sram_w_data,
    input  sram_wen,
    input  sram_ren,
    output sram_r_data
  );
endinterface

// File: rtl/dyt_mem_align.sv
// Byte-lane steering between a 32-bit word SRAM and sub-word accesses.
// Pure combinational: write mask, store replication, load extract/extend.
module dyt_mem_align
  import common_types::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lo,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rraw,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wrep,
  output logic [31:0] o_rfmt
);

  logic [31:0] w_sh;

  assign w_sh = i_rraw >> {i_lo, 3'b000};

  // Lane mask and store data replicated into every lane.
  always_comb begin
    o_wmask = 4'b0000;
    o_wrep  = 32'h0;
    case (i_size)
      SZ_BYTE: begin
        o_wmask = 4'b0001 << i_lo;
        o_wrep  = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_wmask = 4'b0011 << i_lo;
        o_wrep  = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_wmask = 4'b1111;
        o_wrep  = i_wdata;
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down and sign/zero extend it.
  always_comb begin
    o_rfmt = 32'h0;
    case (i_size)
      SZ_BYTE:
        o_rfmt = i_uns ? {24'h0, w_sh[7:0]}
                       : {{24{w_sh[7]}}, w_sh[7:0]};
      SZ_HALF:
        o_rfmt = i_uns ? {16'h0, w_sh[15:0]}
                       : {{16{w_sh[15]}}, w_sh[15:0]};
      SZ_WORD:
        o_rfmt = w_sh;
      default: ;
    endcase
  end

endmodule

// File: rtl/dyt_sram_ctrl.sv
// Single-outstanding load/store controller in front of a word SRAM.
// Request -> WRITE or READ (latency counted down) -> held response.
module dyt_sram_ctrl
  import common_types::*;
#(
  parameter int SRAM_READ_LATENCY = SRAM_RD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  dyt_sram_if.ctrl    sram_if
);

  localparam int CW = (SRAM_READ_LATENCY > 1) ?
                      $clog2(SRAM_READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SRAM_READ_LATENCY - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_state_n;

  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [1:0]    r_size;
  logic          r_uns;
  logic          r_wen;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_acc;
  logic          w_bad;
  logic [3:0]    w_mask;
  logic [31:0]   w_wrep;
  logic [31:0]   w_rfmt;

  assign req_ready  = (r_state == IDLE);
  assign w_acc      = req_valid & req_ready;
  assign w_bad      = bad_access(req_size, req_addr[1:0]);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  dyt_mem_align u_align (
    .i_size  (r_size),
    .i_lo    (r_addr[1:0]),
    .i_uns   (r_uns),
    .i_wdata (r_wdata),
    .i_rraw  (sram_if.sram_r_data),
    .o_wmask (w_mask),
    .o_wrep  (w_wrep),
    .o_rfmt  (w_rfmt)
  );

  // SRAM strobes decoded from state so reset clears them at once.
  always_comb begin
    sram_if.sram_address = 32'h0;
    sram_if.sram_w_data  = 32'h0;
    sram_if.sram_wen     = 4'h0;
    sram_if.sram_ren     = 1'b0;
    case (r_state)
      WRITE: begin
        sram_if.sram_address = {2'b00, r_addr[31:2]};
        sram_if.sram_w_data  = w_wrep;
        sram_if.sram_wen     = w_mask;
      end
      READ: begin
        sram_if.sram_address = {2'b00, r_addr[31:2]};
        sram_if.sram_ren     = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:
        if (req_valid) begin
          if (w_bad)        w_state_n = RESP;
          else if (req_wen) w_state_n = WRITE;
          else              w_state_n = READ;
        end
      WRITE: w_state_n = RESP;
      READ:  if (r_cnt == '0) w_state_n = RESP;
      RESP:  if (resp_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Request capture, read countdown and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_wen   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_wen   <= req_wen;
      r_err   <= w_bad;
      r_rdata <= 32'h0;
      r_cnt   <= CNT_INIT;
    end else if (r_state == READ) begin
      if (r_cnt == '0) r_rdata <= w_rfmt;
      else             r_cnt   <= r_cnt - CW'(1);
    end else if (resp_valid && resp_ready) begin
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end
  end

endmodule

// File: tb/tb_dyt_sram_ctrl.sv
// Directed plus randomized bench for dyt_sram_ctrl.
// Byte-array reference memory predicts data, errors, masks and timing.
module tb_dyt_sram_ctrl;
  import common_types::*;

  localparam int L = SRAM_RD_LAT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_mis = 0;

  dyt_sram_if sif ();

  dyt_sram_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .sram_if      (sif.ctrl)
  );

  always #5 clk = ~clk;

  // Word SRAM device: data appears L cycles after the address is presented.
  bit   [31:0] smem  [0:63];
  logic [31:0] rpipe [0:L-2];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sif.sram_wen[b])
        smem[sif.sram_address[5:0]][8*b +: 8] <= sif.sram_w_data[8*b +: 8];
    if (sif.sram_ren) rpipe[0] <= smem[sif.sram_address[5:0]];
    for (int k = 1; k < L - 1; k++) rpipe[k] <= rpipe[k-1];
  end

  assign sif.sram_r_data = rpipe[L-2];

  // Reference model: flat byte memory.
  bit [7:0] rmem [0:255];

  function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (a % (32'd1 << sz) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                           input logic [31:0] a,
                                           input logic uns);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[int'(a[7:0]) + i];
    if (!uns && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [1:0] sz,
                                          input logic [31:0] a);
    logic [3:0] m;
    m = 4'h0;
    for (int i = 0; i < (1 << sz); i++) m[int'(a[1:0]) + i] = 1'b1;
    return m;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
    for (int i = 0; i < (1 << sz); i++) rmem[int'(a[7:0]) + i] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction with latency, strobe and response checks.
  task automatic do_req(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] sz,
                        input logic uns, input int hold, input string tag);
    logic [31:0] e_rd;
    bit          e_err;
    int          e_lat;
    int          lat, nw, nr;
    logic [3:0]  w_seen;
    logic [31:0] a_seen;
    e_err = is_err(sz, addr);
    e_lat = e_err ? 1 : (wen ? 2 : L + 1);
    e_rd  = (e_err || wen) ? 32'h0 : ref_load(sz, addr, uns);
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = sz; req_unsigned = uns; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nw = 0; nr = 0; w_seen = 4'h0; a_seen = 32'h0;
    while (!resp_valid && lat < 40) begin
      if (sif.sram_wen != 4'h0) begin
        nw++; w_seen = sif.sram_wen; a_seen = sif.sram_address;
      end
      if (sif.sram_ren) begin
        nr++; a_seen = sif.sram_address;
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
    chk({tag, ".rdata"}, resp_rdata, e_rd);
    chk({tag, ".err"}, 32'(resp_err), 32'(e_err));
    chk({tag, ".nwen"}, 32'(nw), (wen && !e_err) ? 32'd1 : 32'd0);
    chk({tag, ".nren"}, 32'(nr), (!wen && !e_err) ? 32'(L) : 32'd0);
    if (wen && !e_err) chk({tag, ".mask"}, 32'(w_seen), 32'(ref_mask(sz, addr)));
    if (!e_err) chk({tag, ".addr"}, a_seen, addr >> 2);
    for (int h = 0; h < hold; h++) begin
      req_wen = 1'b1; req_addr = 32'h80; req_size = 2'd2;
      req_wdata = 32'h5A5A5A5A; req_valid = 1'b1;
      @(negedge clk);
      chk({tag, ".hold_v"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_d"}, resp_rdata, e_rd);
      chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".done_v"}, 32'(resp_valid), 32'd0);
    chk({tag, ".idle"}, 32'(req_ready), 32'd1);
    if (wen && !e_err) ref_store(sz, addr, wdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] acc_v, wen_v, rv_v;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.wen", 32'(sif.sram_wen), 32'd0);
    chk("rst.ren", 32'(sif.sram_ren), 32'd0);
    chk("rst.addr", sif.sram_address, 32'd0);
    chk("rst.wdata", sif.sram_w_data, 32'd0);
    chk("rst.rv", 32'(resp_valid), 32'd0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy", 32'(req_ready), 32'd1);

    // Word store then load.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, "sw10");
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "lw10");

    // Byte store at lane 3, signed and unsigned reload.
    do_req(1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0, 0, "sb13");
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, "lb13");
    do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, "lbu13");

    // Misaligned half load.
    do_req(1'b0, 32'h01, 32'h0, 2'd1, 1'b0, 0, "lh01");

    // Response held off for 5 cycles with a competing request.
    do_req(1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 5, "hold");

    // Reset while in READ.
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h10; req_size = 2'd2;
    req_unsigned = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mrst.inread", 32'(sif.sram_ren), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst.ren", 32'(sif.sram_ren), 32'd0);
    chk("mrst.wen", 32'(sif.sram_wen), 32'd0);
    chk("mrst.addr", sif.sram_address, 32'd0);
    chk("mrst.rv", 32'(resp_valid), 32'd0);
    chk("mrst.rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst.norsp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "mrst.lw");

    // Back-to-back stores with the response always consumed.
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h40; req_wdata = 32'h01234567;
    req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    resp_ready = 1'b1;
    acc_v = '0; wen_v = '0; rv_v = '0;
    for (int c = 0; c < 9; c++) begin
      acc_v[c] = req_valid & req_ready;
      wen_v[c] = (sif.sram_wen != 4'h0);
      rv_v[c]  = resp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    ref_store(2'd2, 32'h40, 32'h01234567);
    chk("b2b.acc", 32'(acc_v), 32'(9'b001001001));
    chk("b2b.wen", 32'(wen_v), 32'(9'b010010010));
    chk("b2b.rv", 32'(rv_v), 32'(9'b100100100));
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, "b2b.lw");

    // Randomized traffic over a small address window.
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
             $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
